// File: rtl/execute_stage_pkg.sv
// Shared word width and encodings for the RV32I execute stage.
// Optional feature macro used by execute_stage: EXEC_FORWARDING_EN.
package execute_stage_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// RV32I ALU: add/sub/and/or/slt; undefined control codes produce zero.
module alu
    import execute_stage_pkg::*;
(
    input  logic [WORD_SIZE-1:0] SrcA,
    input  logic [WORD_SIZE-1:0] SrcB,
    input  logic [2:0]           ALUControl,
    output logic [WORD_SIZE-1:0] ALUResult,
    output logic                 Zero
);

    // Operation select
    always_comb begin
        ALUResult = {WORD_SIZE{1'b0}};
        case (ALUControl)
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_SLT: ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
            default: ALUResult = {WORD_SIZE{1'b0}};
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Forwarding muxes are built only when EXEC_FORWARDING_EN is defined.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] RD1E,
    input  logic [WORD_SIZE-1:0] RD2E,
    input  logic [WORD_SIZE-1:0] PCE,
    input  logic [WORD_SIZE-1:0] PCPlus4E,
    input  logic [WORD_SIZE-1:0] ImmExtE,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    input  logic                 JumpE,
    input  logic                 BranchE,
    input  logic                 ALUSrcE,
    input  logic [1:0]           ResultSrcE,
    input  logic [2:0]           ALUControlE,
    input  logic [1:0]           ForwardAE,
    input  logic [1:0]           ForwardBE,
    input  logic [WORD_SIZE-1:0] ResultW,
    output logic                 PCSrcE,
    output logic [WORD_SIZE-1:0] PCTargetE,
    output logic [4:0]           Rs1EH,
    output logic [4:0]           Rs2EH,
    output logic [4:0]           RdEH,
    output logic                 ResultSrcE0H,
    output logic [WORD_SIZE-1:0] ALUResultM,
    output logic [WORD_SIZE-1:0] WriteDataM,
    output logic [WORD_SIZE-1:0] PCPlus4M,
    output logic [4:0]           RdM,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM
);

    logic [WORD_SIZE-1:0] src_a_s;
    logic [WORD_SIZE-1:0] src_b_s;
    logic [WORD_SIZE-1:0] write_data_s;
    logic [WORD_SIZE-1:0] alu_result_s;
    logic                 zero_s;

    logic [WORD_SIZE-1:0] alu_result_q, write_data_q, pc_plus4_q;
    logic [WORD_SIZE-1:0] alu_result_d, write_data_d, pc_plus4_d;
    logic [4:0]           rd_q, rd_d;
    logic                 reg_write_q, reg_write_d;
    logic                 mem_write_q, mem_write_d;
    logic [1:0]           result_src_q, result_src_d;

`ifdef EXEC_FORWARDING_EN
    // Operand forwarding; MEM-over-WB priority is already resolved by the hazard unit
    always_comb begin
        src_a_s      = RD1E;
        write_data_s = RD2E;
        case (ForwardAE)
            FWD_WB:  src_a_s = ResultW;
            FWD_MEM: src_a_s = alu_result_q;
            default: src_a_s = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  write_data_s = ResultW;
            FWD_MEM: write_data_s = alu_result_q;
            default: write_data_s = RD2E;
        endcase
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{ForwardAE, ForwardBE, ResultW};
    assign src_a_s      = RD1E;
    assign write_data_s = RD2E;
`endif

    assign src_b_s = ALUSrcE ? ImmExtE : write_data_s;

    alu u_alu (
        .SrcA       (src_a_s),
        .SrcB       (src_b_s),
        .ALUControl (ALUControlE),
        .ALUResult  (alu_result_s),
        .Zero       (zero_s)
    );

    assign PCSrcE       = JumpE | (BranchE & zero_s);
    assign PCTargetE    = PCE + ImmExtE;
    assign Rs1EH        = Rs1E;
    assign Rs2EH        = Rs2E;
    assign RdEH         = RdE;
    assign ResultSrcE0H = ResultSrcE[0];

    assign alu_result_d = alu_result_s;
    assign write_data_d = write_data_s;
    assign pc_plus4_d   = PCPlus4E;
    assign rd_d         = RdE;
    assign reg_write_d  = RegWriteE;
    assign mem_write_d  = MemWriteE;
    assign result_src_d = ResultSrcE;

    // EX/MEM pipeline register; reset discards the instruction in EX
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            pc_plus4_q   <= 32'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors queue expected EX/MEM contents.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic        PCSrcE, ResultSrcE0H, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  Rs1EH, Rs2EH, RdEH, RdM;
    logic [1:0]  ResultSrcM;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .Rs1EH(Rs1EH), .Rs2EH(Rs2EH), .RdEH(RdEH), .ResultSrcE0H(ResultSrcE0H),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    task automatic clr();
        RD1E = 32'd0; RD2E = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0; ImmExtE = 32'd0;
        ResultW = 32'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0;
        ResultSrcE = 2'b00; ForwardAE = 2'b00; ForwardBE = 2'b00; ALUControlE = 3'b000;
    endtask

    task automatic chk_comb(input string name, input logic pcsrc, input logic [31:0] tgt);
        #1;
        check({name, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, pcsrc});
        check({name, ".PCTargetE"}, PCTargetE, tgt);
    endtask

    task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                         input logic mw, input logic [1:0] rs);
        exp_t e;
        e.name = name; e.alu = alu; e.wd = wd; e.pc4 = pc4;
        e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rs;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the EX/MEM register just after each edge that carries a queued instruction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".ALUResultM"}, ALUResultM, e.alu);
                check({e.name, ".WriteDataM"}, WriteDataM, e.wd);
                check({e.name, ".PCPlus4M"}, PCPlus4M, e.pc4);
                check({e.name, ".RdM"}, {27'd0, RdM}, {27'd0, e.rd});
                check({e.name, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, e.rw});
                check({e.name, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, e.mw});
                check({e.name, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, e.rs});
            end
        end
    end

    // Stimulus: inputs change on the falling edge, combinational outputs checked before the rising edge
    initial begin
        rst = 1'b1;
        clr();

        @(negedge clk);
        rst = 1'b1; clr();
        RD1E = 32'd5; ImmExtE = 32'd7; ALUSrcE = 1'b1; RdE = 5'd3; RegWriteE = 1'b1;
        MemWriteE = 1'b1; ResultSrcE = 2'b10; PCPlus4E = 32'h44; PCE = 32'h10;
        chk_comb("reset_comb", 1'b0, 32'h17);
        issue("reset", 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        rst = 1'b0;
        Rs1E = 5'd1; Rs2E = 5'd2;
        #1;
        check("hz.Rs1EH", {27'd0, Rs1EH}, 32'd1);
        check("hz.Rs2EH", {27'd0, Rs2EH}, 32'd2);
        check("hz.RdEH", {27'd0, RdEH}, 32'd3);
        check("hz.ResultSrcE0H_pc4", {31'd0, ResultSrcE0H}, 32'd0);
        issue("release", 32'd12, 32'd0, 32'h44, 5'd3, 1'b1, 1'b1, 2'b10);

        @(negedge clk); clr();
        RD1E = 32'd5; ImmExtE = 32'd7; ALUSrcE = 1'b1; RdE = 5'd3; RegWriteE = 1'b1;
        issue("addi", 32'd12, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd2;
        issue("add_wrap", 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b101;
        issue("slt_neg", 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'd1; RD2E = 32'hFFFF_FFFF; ALUControlE = 3'b101;
        issue("slt_swap", 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'd9; RD2E = 32'd9; ALUControlE = 3'b001; BranchE = 1'b1;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        chk_comb("beq_taken", 1'b1, 32'hF8);
        issue("beq_taken", 32'd0, 32'd9, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'd9; RD2E = 32'd3; ALUControlE = 3'b001; BranchE = 1'b1;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        chk_comb("beq_not", 1'b0, 32'hF8);
        issue("beq_not", 32'd6, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'h0000_F0F0; RD2E = 32'h0000_FF00; ALUControlE = 3'b010;
        issue("and", 32'h0000_F000, 32'h0000_FF00, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'h0000_00F0; RD2E = 32'h0000_0F00; ALUControlE = 3'b011;
        issue("or", 32'h0000_0FF0, 32'h0000_0F00, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'd5; RD2E = 32'd3; ALUControlE = 3'b111;
        issue("undef_op", 32'd0, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'h100; ImmExtE = 32'd4; ALUSrcE = 1'b1; ResultSrcE = 2'b01;
        RegWriteE = 1'b1; RdE = 5'd5;
        #1;
        check("hz.ResultSrcE0H_load", {31'd0, ResultSrcE0H}, 32'd1);
        issue("load", 32'h104, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 2'b01);

        @(negedge clk); clr();
        RD1E = 32'd20;
        issue("fwd_producer", 32'd20, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd4;
`ifdef EXEC_FORWARDING_EN
        issue("fwd_consumer", 32'd24, 32'd4, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
`else
        issue("fwd_consumer", 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
`endif

        @(negedge clk); clr();
        JumpE = 1'b1; ResultSrcE = 2'b10; PCPlus4E = 32'h44; PCE = 32'h40; ImmExtE = 32'h20;
        RegWriteE = 1'b1; RdE = 5'd1;
        chk_comb("jal", 1'b1, 32'h60);
        issue("jal", 32'd0, 32'd0, 32'h44, 5'd1, 1'b1, 1'b0, 2'b10);

        @(negedge clk); clr();
        chk_comb("bubble", 1'b0, 32'd0);
        issue("bubble", 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk); clr();
        RD1E = 32'd7; RD2E = 32'd8; RdE = 5'd9; RegWriteE = 1'b1; MemWriteE = 1'b1;
        PCPlus4E = 32'h88; ResultSrcE = 2'b10;
        issue("pre_reset", 32'd15, 32'd8, 32'h88, 5'd9, 1'b1, 1'b1, 2'b10);

        @(negedge clk);
        rst = 1'b1;
        issue("mid_reset", 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        rst = 1'b0; clr();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
